apb_req_arbiter: RTL and testbench

APB master that shares the single APB slave register file between NUM_REQ on-chip requesters. Each requester hands over one transfer at a time through a valid/ready port. The block arbitrates round-robin, drives the APB SETUP/ACCESS sequence, waits on PREADY with a bounded timeout, and returns read data or an error to the winning requester.

---
 rtl/apb_req_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Shares one APB slave between NUM_REQ requesters. Each requester hands over
//   one transfer at a time on a valid/ready port. Arbitration is round-robin
//   starting after the last winner. The block runs the APB SETUP/ACCESS
//   sequence and waits on PREADY with an optional timeout. It then pulses
//   rsp_valid to the winning requester, with read data or an error flag.
//
// Ports
//   PCLK, PRESETn        clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_write/addr/wdata/strb  per-requester transfer, requester i in slice i
//   rsp_valid            per-requester one-cycle completion pulse
//   rsp_rdata, rsp_err   shared response data and timeout flag, valid with rsp_valid
//   PSELx..PSTRB         APB master outputs
//   PRDATA, PREADY       APB slave inputs, only looked at in ACCESS
module apb_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_strb,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             PSELx,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        win_q, win_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    grant_found;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand_idx;

    // Round-robin search: first valid requester strictly after ptr, wrapping,
    // so the last winner is considered last.
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        req_ready   = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    ptr_d   = grant_idx;
                    win_d   = grant_idx;
                    write_d = req_write[grant_idx];
                    addr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    strb_d  = req_strb[grant_idx*STRB_WIDTH +: STRB_WIDTH];
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so a completion on the timeout edge
                // is reported as a normal transfer.
                if (PREADY) begin
                    state_d            = IDLE;
                    rsp_valid_d[win_q] = 1'b1;
                    rsp_rdata_d        = write_q ? '0 : PRDATA;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES))) begin
                    state_d            = IDLE;
                    rsp_valid_d[win_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: the latched transfer fields are reset too, because they drive the
    // APB outputs directly and those must read zero out of reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            win_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // APB outputs come straight from the latched transfer, so they cannot
    // move during SETUP/ACCESS. Reads never expose write data or strobes.
    assign PSELx   = (state_q != IDLE);
    assign PENABLE = (state_q == ACCESS);
    assign PWRITE  = write_q;
    assign PADDR   = addr_q;
    assign PWDATA  = write_q ? wdata_q : '0;
    assign PSTRB   = write_q ? strb_q  : '0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter. Two instances share all inputs: u_dut
// with TIMEOUT_CYCLES=16 and u_dut_b with TIMEOUT_CYCLES=4. A small register
// file slave answers PRDATA from u_dut's PADDR. Inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic        PREADY;
    logic [31:0] PRDATA;

    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata, PADDR, PWDATA;
    logic        rsp_err, PSELx, PENABLE, PWRITE;
    logic [3:0]  PSTRB;

    logic [1:0]  req_ready_b, rsp_valid_b;
    logic [31:0] rsp_rdata_b, PADDR_b, PWDATA_b;
    logic        rsp_err_b, PSELx_b, PENABLE_b, PWRITE_b;
    logic [3:0]  PSTRB_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:15];

    always #5 PCLK = ~PCLK;

    apb_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REQ(2), .TIMEOUT_CYCLES(16)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    apb_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REQ(2), .TIMEOUT_CYCLES(4)) u_dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
        .PSELx(PSELx_b), .PENABLE(PENABLE_b), .PWRITE(PWRITE_b), .PADDR(PADDR_b),
        .PWDATA(PWDATA_b), .PSTRB(PSTRB_b), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // Slave register file: word index PADDR[5:2], location 2 preloaded.
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h12345678;
        end else if (PSELx && PENABLE && PREADY && PWRITE) begin
            mem[PADDR[5:2]] <= PWDATA;
        end
    end
    assign PRDATA = mem[PADDR[5:2]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[i]          = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4]    = s;
        req_valid[i]          = 1'b1;
    endtask

    task automatic test_reset;
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0; PREADY = 1'b1;
        repeat (2) @(negedge PCLK);
        checks++; if ({PSELx, PENABLE, PWRITE} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b expected 000", {PSELx, PENABLE, PWRITE}); end
        checks++; if ({PADDR, PWDATA, PSTRB} !== 68'h0) begin errors++; $display("FAIL rst_apb_data: got %h expected 0", {PADDR, PWDATA, PSTRB}); end
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin errors++; $display("FAIL rst_rsp: got %h expected 0", {rsp_valid, rsp_err, rsp_rdata}); end
        checks++; if ({PSELx_b, PENABLE_b, rsp_valid_b} !== 4'b0) begin errors++; $display("FAIL rst_b: got %b expected 0000", {PSELx_b, PENABLE_b, rsp_valid_b}); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready_idle: got %b expected 00", req_ready); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_ptr_first: got %b expected 01", req_ready); end
        req_valid = 2'b00;
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic test_write_read;
        set_req(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        PREADY = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
        @(negedge PCLK); req_valid = '0;
        checks++; if ({PSELx, PENABLE, PWRITE} !== 3'b101) begin errors++; $display("FAIL wr_setup_ctrl: got %b expected 101", {PSELx, PENABLE, PWRITE}); end
        checks++; if ({PADDR, PWDATA, PSTRB} !== {32'h4, 32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL wr_setup_data: got %h expected %h", {PADDR, PWDATA, PSTRB}, {32'h4, 32'hDEADBEEF, 4'hF}); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL wr_setup_ready: got %b expected 00", req_ready); end
        @(negedge PCLK);
        checks++; if ({PSELx, PENABLE, PSTRB} !== 6'b11_1111) begin errors++; $display("FAIL wr_access: got %b expected 111111", {PSELx, PENABLE, PSTRB}); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_early_rsp: got %b expected 00", rsp_valid); end
        @(negedge PCLK);
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h0}) begin errors++; $display("FAIL wr_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 32'h0}); end
        checks++; if (PSELx !== 1'b0) begin errors++; $display("FAIL wr_idle_psel: got %b expected 0", PSELx); end
        // Completion IDLE cycle accepts the read-back.
        set_req(0, 1'b0, 32'h4, 32'hDEADBEEF, 4'hF);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
        @(negedge PCLK); req_valid = '0;
        checks++; if ({PWRITE, PWDATA, PSTRB} !== 37'h0) begin errors++; $display("FAIL rd_setup_masked: got %h expected 0", {PWRITE, PWDATA, PSTRB}); end
        repeat (2) @(negedge PCLK);
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL rd_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 32'hDEADBEEF}); end
        @(negedge PCLK);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_one_cycle: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_read_strobes;
        set_req(1, 1'b0, 32'h8, 32'hCAFEF00D, 4'hF);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rs_ready: got %b expected 10", req_ready); end
        @(negedge PCLK); req_valid = '0;
        checks++; if ({PSELx, PENABLE, PWRITE, PSTRB, PWDATA, PADDR} !== {3'b100, 4'h0, 32'h0, 32'h8}) begin errors++; $display("FAIL rs_setup: got %h expected %h", {PSELx, PENABLE, PWRITE, PSTRB, PWDATA, PADDR}, {3'b100, 4'h0, 32'h0, 32'h8}); end
        @(negedge PCLK);
        checks++; if ({PSELx, PENABLE, PWRITE, PSTRB} !== 7'b110_0000) begin errors++; $display("FAIL rs_access: got %b expected 1100000", {PSELx, PENABLE, PWRITE, PSTRB}); end
        @(negedge PCLK);
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h12345678}) begin errors++; $display("FAIL rs_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b0, 32'h12345678}); end
    endtask

    task automatic test_round_robin;
        logic [5:0] grants;
        int n;
        int c;
        grants = '0; n = 0; c = 0;
        set_req(0, 1'b0, 32'h4, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h8, 32'h0, 4'hF);
        #1;
        while (n < 6 && c < 40) begin
            if (req_ready !== 2'b00) begin
                checks++; if (!$onehot(req_ready) || PSELx !== 1'b0) begin errors++; $display("FAIL rr_grant_shape: got ready %b psel %b expected one-hot in IDLE", req_ready, PSELx); end
                grants[n] = req_ready[1];
                n++;
            end
            c++;
            if (n < 6) begin @(negedge PCLK); #1; end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL rr_count: got %0d grants expected 6", n); end
        @(negedge PCLK); req_valid = '0;
        checks++; if (grants !== 6'b101010) begin errors++; $display("FAIL rr_order: got %b expected 101010", grants); end
        repeat (2) @(negedge PCLK);
        checks++; if ({rsp_valid, rsp_rdata} !== {2'b10, 32'h12345678}) begin errors++; $display("FAIL rr_last_rsp: got %h expected %h", {rsp_valid, rsp_rdata}, {2'b10, 32'h12345678}); end
        @(negedge PCLK);
    endtask

    task automatic test_wait_states;
        set_req(0, 1'b1, 32'hC, 32'h0BADF00D, 4'h3);
        PREADY = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ws_ready: got %b expected 01", req_ready); end
        @(negedge PCLK); req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge PCLK);
            checks++; if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid} !== {3'b111, 32'hC, 32'h0BADF00D, 4'h3, 2'b00}) begin errors++; $display("FAIL ws_access_%0d: got %h expected %h", k, {PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid}, {3'b111, 32'hC, 32'h0BADF00D, 4'h3, 2'b00}); end
            if (k == 4) PREADY = 1'b1;
        end
        @(negedge PCLK);
        checks++; if ({rsp_valid, rsp_err, PENABLE} !== 4'b0100) begin errors++; $display("FAIL ws_rsp: got %b expected 0100", {rsp_valid, rsp_err, PENABLE}); end
        checks++; if ({rsp_valid_b, rsp_err_b} !== 3'b010) begin errors++; $display("FAIL ws_rsp_b: got %b expected 010", {rsp_valid_b, rsp_err_b}); end
    endtask

    task automatic test_timeout;
        set_req(0, 1'b0, 32'h8, 32'h0, 4'hF);
        PREADY = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL to_ready: got %b expected 01", req_ready); end
        @(negedge PCLK); req_valid = '0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge PCLK);
            if (k <= 17) begin
                checks++; if (PENABLE !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL to_a_wait_%0d: got penable %b rsp %b expected 1 00", k, PENABLE, rsp_valid); end
            end else begin
                checks++; if ({rsp_valid, rsp_err, rsp_rdata, PSELx} !== {2'b01, 1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL to_a_abort: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata, PSELx}, {2'b01, 1'b1, 32'h0, 1'b0}); end
            end
            if (k <= 5) begin
                checks++; if (PENABLE_b !== 1'b1) begin errors++; $display("FAIL to_b_wait_%0d: got %b expected 1", k, PENABLE_b); end
            end else if (k == 6) begin
                checks++; if ({rsp_valid_b, rsp_err_b, rsp_rdata_b, PSELx_b} !== {2'b01, 1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL to_b_abort: got %h expected %h", {rsp_valid_b, rsp_err_b, rsp_rdata_b, PSELx_b}, {2'b01, 1'b1, 32'h0, 1'b0}); end
            end else begin
                checks++; if ({rsp_valid_b, PSELx_b} !== 3'b000) begin errors++; $display("FAIL to_b_idle_%0d: got %b expected 000", k, {rsp_valid_b, PSELx_b}); end
            end
        end
        // Next request proceeds normally on both.
        PREADY = 1'b1;
        set_req(1, 1'b0, 32'h8, 32'h0, 4'hF);
        #1;
        checks++; if ({req_ready, req_ready_b} !== 4'b1010) begin errors++; $display("FAIL to_next_ready: got %b expected 1010", {req_ready, req_ready_b}); end
        @(negedge PCLK); req_valid = '0;
        repeat (2) @(negedge PCLK);
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h12345678}) begin errors++; $display("FAIL to_next_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 1'b0, 32'h12345678}); end
        checks++; if ({rsp_valid_b, rsp_err_b, rsp_rdata_b} !== {2'b10, 1'b0, 32'h12345678}) begin errors++; $display("FAIL to_next_rsp_b: got %h expected %h", {rsp_valid_b, rsp_err_b, rsp_rdata_b}, {2'b10, 1'b0, 32'h12345678}); end
    endtask

    task automatic test_timeout_boundary;
        set_req(0, 1'b0, 32'h8, 32'h0, 4'hF);
        PREADY = 1'b0;
        #1;
        @(negedge PCLK); req_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge PCLK);
            if (k == 5) PREADY = 1'b1;
        end
        @(negedge PCLK);
        checks++; if ({rsp_valid_b, rsp_err_b, rsp_rdata_b} !== {2'b01, 1'b0, 32'h12345678}) begin errors++; $display("FAIL tb_ready_wins_b: got %h expected %h", {rsp_valid_b, rsp_err_b, rsp_rdata_b}, {2'b01, 1'b0, 32'h12345678}); end
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h12345678}) begin errors++; $display("FAIL tb_ready_wins: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 32'h12345678}); end
    endtask

    task automatic test_reset_mid;
        set_req(0, 1'b1, 32'h10, 32'h55AA55AA, 4'hF);
        PREADY = 1'b0;
        #1;
        @(negedge PCLK); req_valid = '0;
        repeat (2) @(negedge PCLK);
        checks++; if ({PSELx, PENABLE} !== 2'b11) begin errors++; $display("FAIL rm_in_access: got %b expected 11", {PSELx, PENABLE}); end
        #2 PRESETn = 1'b0;
        #1;
        checks++; if ({PSELx, PENABLE, PSELx_b, PENABLE_b} !== 4'b0000) begin errors++; $display("FAIL rm_drop: got %b expected 0000", {PSELx, PENABLE, PSELx_b, PENABLE_b}); end
        set_req(1, 1'b0, 32'h8, 32'h0, 4'hF);
        set_req(0, 1'b0, 32'h4, 32'h0, 4'hF);
        repeat (2) begin
            @(negedge PCLK);
            checks++; if ({rsp_valid, rsp_valid_b} !== 4'b0000) begin errors++; $display("FAIL rm_no_rsp: got %b expected 0000", {rsp_valid, rsp_valid_b}); end
        end
        PRESETn = 1'b1;
        #1;
        checks++; if ({req_ready, req_ready_b} !== 4'b0101) begin errors++; $display("FAIL rm_ptr_reset: got %b expected 0101", {req_ready, req_ready_b}); end
        @(negedge PCLK); req_valid = '0; PREADY = 1'b1;
        checks++; if ({rsp_valid, PSELx, PADDR} !== {2'b00, 1'b1, 32'h4}) begin errors++; $display("FAIL rm_setup: got %h expected %h", {rsp_valid, PSELx, PADDR}, {2'b00, 1'b1, 32'h4}); end
        repeat (2) @(negedge PCLK);
        checks++; if ({rsp_valid, rsp_err} !== 3'b010) begin errors++; $display("FAIL rm_after_rsp: got %b expected 010", {rsp_valid, rsp_err}); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_strobes();
        test_round_robin();
        test_wait_states();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
